arbitro_mem: RTL and testbench
==============================

Name: arbitro_mem

Overview:
- Shares the core's single 32-bit memory port between two requesters: the instruction-fetch port and the data load/store port.
- Each access is sequenced as a registered request/ready transaction on the memory side and a one-cycle acknowledge on the requester side.
- Provides round-robin arbitration and a watchdog timeout that flags bus errors.
- Sits between the core pipeline (already-aligned store data and byte mask from the store unit) and memory/peripherals. Load alignment stays downstream of d_rdata.

Parameters:
- TIMEOUT, 255: max cycles in ACCESS waiting for mem_ready before abort; 0 disables the watchdog.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high and stable until if_ack
- if_addr  in  32  fetch word address
- if_rdata  out  32  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held high and stable until d_ack
- d_addr  in  32  data address
- d_wdata  in  32  lane-aligned store data
- d_mask  in  4  byte-write mask; 4'b0000 = load
- d_rdata  out  32  raw memory word for a load, valid while d_ack=1
- d_ack  out  1  one-cycle data completion pulse
- mem_valid  out  1  memory transaction active
- mem_addr  out  32  memory address, bits [1:0] forced to 0
- mem_wdata  out  32  store data
- mem_wstrb  out  4  byte strobes; 0 = read
- mem_ready  in  1  memory completes the transaction this cycle
- mem_rdata  in  32  read data, sampled when mem_valid & mem_ready
- bus_err  out  1  one-cycle pulse coincident with an ack on timeout

Behaviour:
- **Reset** (resetn=0, async): state=IDLE; last_grant=FETCH; counter=0. All outputs are 0: mem_valid, mem_addr, mem_wdata, mem_wstrb, if_ack, d_ack, bus_err, if_rdata, d_rdata. Reset mid-transaction abandons it with no ack; requesters re-request after reset.
- All outputs are registered. mem_* are driven from latched copies, not directly from requester inputs.
- **IDLE:**
  - Only d_req → grant DATA. Only if_req → grant FETCH.
  - Both pending → grant the requester that is not last_grant. After reset, DATA wins.
  - On grant: latch address/wdata/mask, set mem_valid=1, update last_grant, counter=0, go to ACCESS.
  - FETCH grant drives mem_wstrb=0 and mem_wdata=0.
- **ACCESS:**
  - mem_valid=1, and mem_addr/mem_wdata/mem_wstrb are held stable.
  - mem_ready=1 → next edge: mem_valid=0, ack of the granted requester=1, go to RESP.
    - FETCH: if_rdata=mem_rdata.
    - DATA load: d_rdata=mem_rdata.
    - DATA store: d_rdata is held unchanged.
  - mem_ready=0 → counter+1. If TIMEOUT≠0 and counter==TIMEOUT-1 with no ready: mem_valid=0, ack=1, bus_err=1, that rdata=32'h0, go to RESP.
- **RESP:** ack and bus_err are high for this single cycle only. The served requester must drop req during this cycle. Its req is ignored here; no arbitration occurs in RESP. Next state is IDLE.
- **Latency:** req seen at edge N → mem_valid at N+1 → (zero-wait ready) ack at N+2 → IDLE at N+3 → next grant possible at N+4.
- **Ignored inputs:** mem_ready while mem_valid=0 is ignored. A requester's req changing while it is being served is ignored; latched values are used.
- **Status signals:** if_ack and d_ack are never high in the same cycle. Only one transaction is outstanding; there is no pipelining.

Test Plan:
- Reset release, if_req=1, if_addr=0x100, mem_ready=1 on first valid cycle, mem_rdata=0x00000013 → mem_valid 1 cycle with mem_addr=0x100 and wstrb=0; next cycle if_ack=1, if_rdata=0x13.
- d_req store, d_addr=0x2002, d_mask=4'b1100, d_wdata=0xABCD0000, ready after 3 wait cycles → mem_addr=0x2000 and wstrb=1100 held 4 cycles; d_ack=1 once; d_rdata unchanged.
- if_req and d_req asserted together and re-asserted after each ack (4 requests) → grants DATA, FETCH, DATA, FETCH; acks never overlap.
- TIMEOUT=4, d load to unmapped address, mem_ready held 0 → mem_valid drops after 4 cycles; d_ack=1, bus_err=1, d_rdata=0 in the same cycle.
- resetn pulsed low during ACCESS → outputs 0 immediately (async); no ack issued; fresh fetch after release completes normally.
- Spurious mem_ready=1 while IDLE → no ack and no state change.

Source files
------------

// File: rtl/arbitro_mem_if.sv
// Bundle of requester-side (fetch/data) and memory-side signals shared by the arbiter.
// The arbiter takes the master view; the core pipeline and memory model take the slave view.
interface arbitro_mem_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_mask;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err;

  modport master (
    input  if_req, if_addr, d_req, d_addr, d_wdata, d_mask, mem_ready, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_valid, mem_addr, mem_wdata,
           mem_wstrb, bus_err
  );

  modport slave (
    output if_req, if_addr, d_req, d_addr, d_wdata, d_mask, mem_ready, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_valid, mem_addr, mem_wdata,
           mem_wstrb, bus_err
  );
endinterface

// File: rtl/arbitro_mem.sv
// Round-robin arbiter sharing one 32-bit memory port between instruction fetch and data
// load/store, with a watchdog that aborts a stalled access and flags bus_err.
module arbitro_mem #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          resetn,
  arbitro_mem_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam bit              WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_e           state_q;
  logic             last_data_q;
  logic             serve_data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_valid_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic [3:0]       mem_wstrb_q;
  logic [31:0]      if_rdata_q;
  logic [31:0]      d_rdata_q;
  logic             if_ack_q;
  logic             d_ack_q;
  logic             bus_err_q;
  logic             grant_any_d;
  logic             grant_data_d;

  // On contention the side that did not win last time is granted
  always_comb begin
    grant_any_d  = 1'b0;
    grant_data_d = 1'b0;
    if (bus.d_req && bus.if_req) begin
      grant_any_d  = 1'b1;
      grant_data_d = ~last_data_q;
    end else if (bus.d_req) begin
      grant_any_d  = 1'b1;
      grant_data_d = 1'b1;
    end else if (bus.if_req) begin
      grant_any_d  = 1'b1;
      grant_data_d = 1'b0;
    end else begin
      grant_any_d  = 1'b0;
      grant_data_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      last_data_q  <= 1'b0;
      serve_data_q <= 1'b0;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'h0;
      if_rdata_q   <= 32'h0;
      d_rdata_q    <= 32'h0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if_ack_q  <= 1'b0;
          d_ack_q   <= 1'b0;
          bus_err_q <= 1'b0;
          if (grant_any_d) begin
            state_q      <= ST_ACCESS;
            mem_valid_q  <= 1'b1;
            serve_data_q <= grant_data_d;
            last_data_q  <= grant_data_d;
            cnt_q        <= '0;
            if (grant_data_d) begin
              mem_addr_q  <= {bus.d_addr[31:2], 2'b00};
              mem_wdata_q <= bus.d_wdata;
              mem_wstrb_q <= bus.d_mask;
            end else begin
              mem_addr_q  <= {bus.if_addr[31:2], 2'b00};
              mem_wdata_q <= 32'h0;
              mem_wstrb_q <= 4'h0;
            end
          end
        end
        ST_ACCESS: begin
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= ST_RESP;
            if (serve_data_q) begin
              d_ack_q <= 1'b1;
              // Stores leave the last load word visible on d_rdata
              if (mem_wstrb_q == 4'b0000) begin
                d_rdata_q <= bus.mem_rdata;
              end
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
            mem_valid_q <= 1'b0;
            bus_err_q   <= 1'b1;
            state_q     <= ST_RESP;
            if (serve_data_q) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= 32'h0;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= 32'h0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if_ack_q  <= 1'b0;
          d_ack_q   <= 1'b0;
          bus_err_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_valid_q <= 1'b0;
          if_ack_q    <= 1'b0;
          d_ack_q     <= 1'b0;
          bus_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_arbitro_mem.sv
// Directed bench for arbitro_mem: expected transactions are queued when requests are driven
// and checked by a monitor when the matching acknowledge appears.
module tb_arbitro_mem;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          vcyc;
  } exp_t;

  logic        clk;
  logic        resetn;
  int          total;
  int          bad;
  int          mem_wait;
  int          wcnt;
  int          vcnt;
  logic        spurious;
  logic [31:0] exp_drd;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_strb;
  exp_t        sb[$];

  arbitro_mem_if bus ();

  arbitro_mem #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem_fn(bus.mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: ready after mem_wait stall cycles, optional spurious ready while idle
  always @(negedge clk) begin
    if (!resetn) begin
      bus.mem_ready = 1'b0;
      wcnt = 0;
    end else if (bus.mem_valid) begin
      bus.mem_ready = (wcnt == mem_wait);
      wcnt++;
    end else begin
      bus.mem_ready = spurious;
      wcnt = 0;
    end
  end

  // Monitor: track the memory-side request, pop and compare on every acknowledge
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      vcnt = 0;
    end else begin
      if (bus.mem_valid) begin
        if (vcnt > 0) begin
          chk("hold_addr", bus.mem_addr, cap_addr);
          chk("hold_strb", 32'(bus.mem_wstrb), 32'(cap_strb));
          chk("hold_wdata", bus.mem_wdata, cap_wdata);
        end
        cap_addr  = bus.mem_addr;
        cap_strb  = bus.mem_wstrb;
        cap_wdata = bus.mem_wdata;
        vcnt++;
      end
      chk("ack_overlap", 32'(bus.if_ack & bus.d_ack), 32'h0);
      if (bus.if_ack || bus.d_ack) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_ack observed if_ack=%b d_ack=%b expected none", bus.if_ack, bus.d_ack);
        end else begin
          e = sb.pop_front();
          chk("ack_side_d", 32'(bus.d_ack), 32'(e.is_d));
          chk("rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
          chk("bus_err", 32'(bus.bus_err), 32'(e.err));
          chk("mem_addr", cap_addr, e.addr);
          chk("mem_wstrb", 32'(cap_strb), 32'(e.strb));
          chk("mem_wdata", cap_wdata, e.wdata);
          chk("valid_cycles", 32'(vcnt), 32'(e.vcyc));
        end
        vcnt = 0;
      end else begin
        chk("err_without_ack", 32'(bus.bus_err), 32'h0);
      end
    end
  end

  task automatic wait_ack(output logic got_d, output logic got_f);
    logic seen;
    seen  = 1'b0;
    got_d = 1'b0;
    got_f = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.d_ack || bus.if_ack) begin
        seen  = 1'b1;
        got_d = bus.d_ack;
        got_f = bus.if_ack;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $error("FAIL ack_timeout observed no ack expected ack within 40 cycles");
    end
  endtask

  task automatic drop(input logic gd, input logic gf);
    if (gd) bus.d_req = 1'b0;
    if (gf) bus.if_req = 1'b0;
  endtask

  task automatic do_op(input logic is_d, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] wd, input int wt, input logic to);
    exp_t e;
    logic gd, gf;
    @(negedge clk);
    mem_wait = wt;
    e.is_d = is_d;
    e.addr = {a[31:2], 2'b00};
    e.err  = to;
    e.vcyc = to ? 4 : wt + 1;
    if (is_d) begin
      bus.d_addr  = a;
      bus.d_mask  = m;
      bus.d_wdata = wd;
      bus.d_req   = 1'b1;
      e.strb  = m;
      e.wdata = wd;
      if (to) exp_drd = 32'h0;
      else if (m == 4'b0000) exp_drd = mem_fn(e.addr);
      e.rdata = exp_drd;
    end else begin
      bus.if_addr = a;
      bus.if_req  = 1'b1;
      e.strb  = 4'h0;
      e.wdata = 32'h0;
      e.rdata = to ? 32'h0 : mem_fn(e.addr);
    end
    sb.push_back(e);
    wait_ack(gd, gf);
    drop(gd, gf);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_mem_valid"}, 32'(bus.mem_valid), 32'h0);
    chk({p, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({p, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    chk({p, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'h0);
    chk({p, "_if_ack"}, 32'(bus.if_ack), 32'h0);
    chk({p, "_d_ack"}, 32'(bus.d_ack), 32'h0);
    chk({p, "_bus_err"}, 32'(bus.bus_err), 32'h0);
    chk({p, "_if_rdata"}, bus.if_rdata, 32'h0);
    chk({p, "_d_rdata"}, bus.d_rdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed no finish expected finish before 100000");
    $fatal(1, "simulation time limit");
  end

  initial begin
    exp_t e;
    logic gd, gf;
    total = 0; bad = 0; mem_wait = 0; spurious = 1'b0; exp_drd = 32'h0;
    resetn = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_mask = 4'h0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    resetn = 1'b1;

    // Single-requester transfers: fetch, load, store with stalls, fetch
    do_op(1'b0, 32'h0000_0100, 4'h0, 32'h0, 0, 1'b0);
    do_op(1'b1, 32'h0000_3001, 4'h0, 32'h0, 0, 1'b0);
    do_op(1'b1, 32'h0000_2002, 4'b1100, 32'hABCD_0000, 3, 1'b0);
    do_op(1'b0, 32'h0000_0104, 4'h0, 32'h0, 1, 1'b0);

    // Contention: both pending and re-requested after each ack -> D, F, D, F
    @(negedge clk);
    mem_wait = 0;
    bus.d_addr = 32'h0000_0400; bus.d_mask = 4'h0; bus.d_wdata = 32'h0; bus.d_req = 1'b1;
    bus.if_addr = 32'h0000_0500; bus.if_req = 1'b1;
    exp_drd = mem_fn(32'h0000_0400);
    e = '{1'b1, 32'h0000_0400, 4'h0, 32'h0, exp_drd, 1'b0, 1};
    sb.push_back(e);
    e = '{1'b0, 32'h0000_0500, 4'h0, 32'h0, mem_fn(32'h0000_0500), 1'b0, 1};
    sb.push_back(e);
    wait_ack(gd, gf); drop(gd, gf);
    @(negedge clk);
    bus.d_addr = 32'h0000_0404; bus.d_req = 1'b1;
    exp_drd = mem_fn(32'h0000_0404);
    e = '{1'b1, 32'h0000_0404, 4'h0, 32'h0, exp_drd, 1'b0, 1};
    sb.push_back(e);
    wait_ack(gd, gf); drop(gd, gf);
    @(negedge clk);
    bus.if_addr = 32'h0000_0504; bus.if_req = 1'b1;
    e = '{1'b0, 32'h0000_0504, 4'h0, 32'h0, mem_fn(32'h0000_0504), 1'b0, 1};
    sb.push_back(e);
    wait_ack(gd, gf); drop(gd, gf);
    wait_ack(gd, gf); drop(gd, gf);

    // Watchdog: memory never answers
    do_op(1'b1, 32'h0000_DEAD, 4'h0, 32'h0, 1000, 1'b1);

    // Spurious ready while idle must be ignored
    @(negedge clk);
    spurious = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("spur_mem_valid", 32'(bus.mem_valid), 32'h0);
    end
    spurious = 1'b0;
    do_op(1'b0, 32'h0000_0208, 4'h0, 32'h0, 0, 1'b0);

    // Asynchronous reset in the middle of an access abandons it
    @(negedge clk);
    mem_wait = 3;
    bus.if_addr = 32'h0000_0600; bus.if_req = 1'b1;
    for (int i = 0; i < 10 && !bus.mem_valid; i++) @(negedge clk);
    chk("midreset_started", 32'(bus.mem_valid), 32'h1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_zero("midreset");
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", 32'(bus.mem_valid), 32'h0);
    do_op(1'b0, 32'h0000_0700, 4'h0, 32'h0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
